// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//   Single owner of every pipeline register enable. Combines the load-use stall
//   request, the ID-stage branch-taken flush and the data-memory busy signal
//   into PC / IF/ID / ID/EX / EX/MEM / MEM/WB write, flush and bubble controls.
//   Enable/flush/bubble outputs are a zero-latency (Mealy) decode of the state
//   and inputs; state, wait counter, pending flush, statistics and timeout are
//   registered.
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-low reset
//   start_i         pipeline run enable
//   stall_req_i     load-use stall request (same-cycle)
//   branch_taken_i  branch resolved taken in ID
//   mem_busy_i      data memory not ready, freeze whole pipeline
//   pc_write_o      PC enable
//   ifid_write_o    IF/ID enable
//   ifid_flush_o    IF/ID clear to NOP
//   idex_write_o    ID/EX enable
//   idex_bubble_o   ID/EX loads NOP
//   exmem_write_o   EX/MEM enable
//   memwb_write_o   MEM/WB enable
//   memwb_bubble_o  MEM/WB loads NOP
//   timeout_o       sticky memory-wait timeout
//   stall_cnt_o     saturating count of stalled (pc_write=0) cycles
//   flush_cnt_o     saturating count of IF/ID flushes
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64,
  parameter int WAIT_W   = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_req_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic             memwb_write_o,
  output logic             memwb_bubble_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    LU_STALL = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  // Output enables plus next-state decode.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    flush_pend_d   = flush_pend_q;
    pc_write_o     = 1'b0;
    ifid_write_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_write_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_write_o  = 1'b0;
    memwb_write_o  = 1'b0;
    memwb_bubble_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN, LU_STALL, MEM_WAIT: begin
        if (mem_busy_i) begin
          // Freeze: nothing advances, MEM/WB takes a NOP so WB does not repeat.
          memwb_bubble_o = 1'b1;
          state_d        = MEM_WAIT;
          if (state_q == MEM_WAIT) begin
            if (wait_cnt_q < WAIT_MAX) begin
              wait_cnt_d = wait_cnt_q + WAIT_ONE;
            end else begin
              wait_cnt_d = wait_cnt_q;
            end
          end else begin
            wait_cnt_d = WAIT_ONE;
          end
          // A taken branch seen while frozen is replayed on release.
          if (branch_taken_i) begin
            flush_pend_d = 1'b1;
          end else begin
            flush_pend_d = flush_pend_q;
          end
        end else if (stall_req_i && (state_q != LU_STALL)) begin
          // Load-use bubble. The branch compare has stale operands here, so
          // branch_taken_i is ignored and any pending flush is kept.
          idex_write_o  = 1'b1;
          idex_bubble_o = 1'b1;
          exmem_write_o = 1'b1;
          memwb_write_o = 1'b1;
          wait_cnt_d    = '0;
          state_d       = LU_STALL;
        end else begin
          pc_write_o    = 1'b1;
          ifid_write_o  = 1'b1;
          idex_write_o  = 1'b1;
          exmem_write_o = 1'b1;
          memwb_write_o = 1'b1;
          ifid_flush_o  = branch_taken_i | flush_pend_q;
          flush_pend_d  = 1'b0;
          wait_cnt_d    = '0;
          state_d       = RUN;
        end

        // Dropping run enable returns to IDLE; this cycle's outputs stand.
        if (!start_i) begin
          state_d      = IDLE;
          flush_pend_d = 1'b0;
          wait_cnt_d   = '0;
        end else begin
          flush_pend_d = flush_pend_d;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Statistics counters and sticky timeout.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;
    if ((state_q != IDLE) && !pc_write_o && (stall_cnt_q != CNT_SAT)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (ifid_flush_o && (flush_cnt_q != CNT_SAT)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    // Sets on the same edge that wait_cnt reaches the limit.
    if (wait_cnt_d == WAIT_MAX) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      timeout_q    <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      flush_pend_q <= flush_pend_d;
      timeout_q    <= timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign timeout_o   = timeout_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (MAX_WAIT shrunk to 4).
// Output vector order: {pc, ifid_w, ifid_f, idex_w, idex_b, exmem, memwb_w, memwb_b}
module tb_pipe_stall_ctrl;

  localparam int CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic             stall_req_i;
  logic             branch_taken_i;
  logic             mem_busy_i;
  logic             pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o;
  logic             idex_bubble_o, exmem_write_o, memwb_write_o, memwb_bubble_o;
  logic             timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] P_IDLE   = 8'b0000_0000;
  localparam logic [7:0] P_NORM   = 8'b1101_0110;
  localparam logic [7:0] P_FLUSH  = 8'b1111_0110;
  localparam logic [7:0] P_STALL  = 8'b0001_1110;
  localparam logic [7:0] P_FREEZE = 8'b0000_0001;

  pipe_stall_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(4), .WAIT_W(7)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .stall_req_i    (stall_req_i),
    .branch_taken_i (branch_taken_i),
    .mem_busy_i     (mem_busy_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_write_o   (idex_write_o),
    .idex_bubble_o  (idex_bubble_o),
    .exmem_write_o  (exmem_write_o),
    .memwb_write_o  (memwb_write_o),
    .memwb_bubble_o (memwb_bubble_o),
    .timeout_o      (timeout_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] outs();
    return {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
            idex_bubble_o, exmem_write_o, memwb_write_o, memwb_bubble_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs just after the falling edge, settle, then caller checks.
  task automatic cyc(input logic s, input logic st, input logic br, input logic mb);
    @(negedge clk_i);
    start_i        = s;
    stall_req_i    = st;
    branch_taken_i = br;
    mem_busy_i     = mb;
    #1;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; stall_req_i = 1'b0;
    branch_taken_i = 1'b0; mem_busy_i = 1'b0;
    #2;
    chk("rst_outs", 32'(outs()), 32'(P_IDLE));
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Start: one IDLE cycle, then full run.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_outs", 32'(outs()), 32'(P_IDLE));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("run_outs", 32'(outs()), 32'(P_NORM));
    chk("run_stall_cnt", 32'(stall_cnt_o), 32'd0);

    // Held load-use request: one bubble only.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu_stall_outs", 32'(outs()), 32'(P_STALL));
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu_masked_outs", 32'(outs()), 32'(P_NORM));
    chk("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);

    // Stall wins over branch; branch alone in LU_STALL flushes.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("stall_br_outs", 32'(outs()), 32'(P_STALL));
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("br_flush_outs", 32'(outs()), 32'(P_FLUSH));
    chk("br_stall_cnt", 32'(stall_cnt_o), 32'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_flush_outs", 32'(outs()), 32'(P_NORM));
    chk("flush_cnt_1", 32'(flush_cnt_o), 32'd1);

    // Three-cycle freeze with branch in freeze cycle 2; flush on release.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("frz1_outs", 32'(outs()), 32'(P_FREEZE));
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("frz2_outs", 32'(outs()), 32'(P_FREEZE));
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("frz3_outs", 32'(outs()), 32'(P_FREEZE));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("release_flush_outs", 32'(outs()), 32'(P_FLUSH));
    chk("frz_stall_cnt", 32'(stall_cnt_o), 32'd5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_release_outs", 32'(outs()), 32'(P_NORM));
    chk("flush_cnt_2", 32'(flush_cnt_o), 32'd2);
    chk("no_timeout_short", 32'(timeout_o), 32'd0);

    // Six-cycle freeze reaches MAX_WAIT=4.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk("long_frz_outs", 32'(outs()), 32'(P_FREEZE));
      if (i == 3) chk("timeout_before", 32'(timeout_o), 32'd0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("long_release_outs", 32'(outs()), 32'(P_NORM));
    chk("timeout_set", 32'(timeout_o), 32'd1);
    chk("long_stall_cnt", 32'(stall_cnt_o), 32'd11);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume_outs", 32'(outs()), 32'(P_NORM));
    chk("timeout_sticky", 32'(timeout_o), 32'd1);

    // Dropping start: current cycle still runs, then IDLE.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stop_cycle_outs", 32'(outs()), 32'(P_NORM));
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stopped_outs", 32'(outs()), 32'(P_IDLE));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_idle_outs", 32'(outs()), 32'(P_IDLE));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_run_outs", 32'(outs()), 32'(P_NORM));

    // Reset during 2nd MEM_WAIT cycle with a pending flush.
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("pre_rst_frz1", 32'(outs()), 32'(P_FREEZE));
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_frz2", 32'(outs()), 32'(P_FREEZE));
    rst_i = 1'b0;
    #1;
    chk("async_rst_outs", 32'(outs()), 32'(P_IDLE));
    chk("async_rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    chk("async_rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
    chk("async_rst_timeout", 32'(timeout_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b1; mem_busy_i = 1'b0;
    #1;
    chk("post_rst_idle_outs", 32'(outs()), 32'(P_IDLE));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_no_flush", 32'(outs()), 32'(P_NORM));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_no_flush2", 32'(outs()), 32'(P_NORM));
    chk("post_rst_flush_cnt", 32'(flush_cnt_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
